// File: rtl/simd_seq_pkg.sv
// simd_seq_pkg: shared state type, default geometry and lane-mask helpers for the vector sequencer
package simd_seq_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, MEMWAIT} seq_state_t;

    localparam int VEC_LANES_DEF      = 16;
    localparam int LANES_PER_BEAT_DEF = 4;
    // Widest lane count beat_mask can describe; callers slice off their VEC_LANES
    localparam int MAX_LANES          = 256;

    function automatic int nbeats(input int vec_lanes, input int lanes_per_beat);
        return vec_lanes / lanes_per_beat;
    endfunction

    function automatic logic [MAX_LANES-1:0] beat_mask(input int idx, input int lanes_per_beat);
        logic [MAX_LANES-1:0] m;
        for (int i = 0; i < MAX_LANES; i++)
            m[i] = (i >= idx * lanes_per_beat) && (i < (idx + 1) * lanes_per_beat);
        return m;
    endfunction

endpackage

// File: rtl/simd_beat_counter.sv
// simd_beat_counter: beat index for the in-flight vector op, wrapping to 0 only when the final beat completes
module simd_beat_counter #(
    parameter int NBEATS = 4,
    parameter int IW     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    output logic [IW-1:0] idx,
    output logic          last
);

    logic [IW-1:0] idx_q, idx_d;

    assign last = idx_q == IW'(NBEATS - 1);
    assign idx  = idx_q;

    // A completed beat steps the index (wrapping after the last); load restarts at beat 0
    always_comb idx_d = advance ? (last ? '0 : idx_q + 1'b1) : (load ? '0 : idx_q);

    // Index register, cleared asynchronously so an abandoned op restarts cleanly
    always_ff @(posedge clk or posedge rst)
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;

endmodule

// File: rtl/simd_vec_sequencer.sv
// simd_vec_sequencer: steps vector ops through lane-group beats and stalls decode while they run
// Optional stall-cycle counter built when SIMD_SEQ_PERF_CNT_EN is defined
module simd_vec_sequencer
    import simd_seq_pkg::*;
#(
    parameter int VEC_LANES      = VEC_LANES_DEF,
    parameter int LANES_PER_BEAT = LANES_PER_BEAT_DEF,
    parameter int NBEATS         = nbeats(VEC_LANES, LANES_PER_BEAT),
    parameter int IW             = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic                 alu_sel,
    input  logic [2:0]           alu_control,
    input  logic                 reg_write,
    input  logic                 mem_write,
    input  logic                 mem_to_reg,
    input  logic                 mem_ack,
    output logic                 stuck,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 beat_valid,
    output logic [IW-1:0]        beat_idx,
    output logic [VEC_LANES-1:0] lane_en,
    output logic [2:0]           alu_ctrl_q,
    output logic                 wb_en,
    output logic                 op_done,
    output logic [31:0]          stall_cycles
);

    seq_state_t           state_q, state_d;
    logic [2:0]           ctrl_q;
    logic                 rw_q, st_q, op_done_q;
    logic                 accept, active, mem_op, cur_st, cur_rw, done_beat, last;
    logic [MAX_LANES-1:0] mask_full;
    logic                 unused_mask;

    // Reset gates acceptance so every output is low while rst is held
    assign accept = !rst && state_q == IDLE && op_valid && alu_sel;

    simd_beat_counter #(.NBEATS(NBEATS), .IW(IW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (beat_valid),
        .idx     (beat_idx),
        .last    (last)
    );

    assign mask_full   = beat_mask(int'(beat_idx), LANES_PER_BEAT);
    assign unused_mask = ^mask_full[MAX_LANES-1:VEC_LANES];

    // Next state and beat/memory outputs; acceptance-cycle values come straight from the inputs
    always_comb begin
        state_d    = state_q;
        active     = accept || state_q != IDLE;
        mem_op     = accept ? (mem_write || mem_to_reg) : state_q == MEMWAIT;
        cur_st     = accept ? mem_write : st_q;
        cur_rw     = accept ? reg_write : rw_q;
        alu_ctrl_q = accept ? alu_control : ctrl_q;
        mem_req    = active && mem_op;
        mem_we     = mem_req && cur_st;
        beat_valid = active && (!mem_op || mem_ack);
        done_beat  = beat_valid && last;
        stuck      = active && !done_beat;
        wb_en      = beat_valid && cur_rw && !cur_st;
        lane_en    = beat_valid ? mask_full[VEC_LANES-1:0] : '0;
        if (accept && !done_beat)
            state_d = mem_op ? MEMWAIT : EXEC;
        else if (state_q != IDLE && done_beat)
            state_d = IDLE;
    end

    // State, op attributes latched at acceptance, and the completion pulse
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            rw_q      <= 1'b0;
            st_q      <= 1'b0;
            op_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_done_q <= done_beat;
            if (accept) begin
                ctrl_q <= alu_control;
                rw_q   <= reg_write;
                st_q   <= mem_write;
            end
        end

    assign op_done = op_done_q;

`ifdef SIMD_SEQ_PERF_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst)
        if (rst) stall_q <= '0;
        else     stall_q <= stall_q + 32'(stuck && stall_q != '1);

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_simd_vec_sequencer.sv
// tb_simd_vec_sequencer: directed checks of vector ALU, store, load, scalar, back-to-back and reset behaviour
module tb_simd_vec_sequencer;

    logic        clk = 1'b0, rst = 1'b1;
    logic        op_valid = 1'b0, alu_sel = 1'b0, reg_write = 1'b0;
    logic        mem_write = 1'b0, mem_to_reg = 1'b0, mem_ack = 1'b0;
    logic [2:0]  alu_control = 3'd0;
    logic        stuck, mem_req, mem_we, beat_valid, wb_en, op_done;
    logic [1:0]  beat_idx;
    logic [15:0] lane_en;
    logic [2:0]  alu_ctrl_q;
    logic [31:0] stall_cycles;
    int          checks = 0, errors = 0;

    simd_vec_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .alu_sel      (alu_sel),
        .alu_control  (alu_control),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .mem_ack      (mem_ack),
        .stuck        (stuck),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .beat_valid   (beat_valid),
        .beat_idx     (beat_idx),
        .lane_en      (lane_en),
        .alu_ctrl_q   (alu_ctrl_q),
        .wb_en        (wb_en),
        .op_done      (op_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op_valid = 0; alu_sel = 0; alu_control = 0; reg_write = 0;
        mem_write = 0; mem_to_reg = 0; mem_ack = 0;
    endtask

    initial begin
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_stuck", stuck, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_op_done", op_done, 0);
        check("rst_alu_ctrl", alu_ctrl_q, 0);
        check("rst_beat_idx", beat_idx, 0);
        check("rst_lane_en", lane_en, 0);
        check("rst_stall", stall_cycles, 0);
        next_cycle();
        rst = 0;
        next_cycle();

        // Vector ALU op: 4 beats, stall in cycles 0-2, op_done in cycle 4
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) begin
                op_valid = 1; alu_sel = 1; alu_control = 3'b010; reg_write = 1;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            check("alu_valid", beat_valid, c < 4);
            check("alu_idx", beat_idx, c < 4 ? c : 0);
            check("alu_lane", lane_en, c < 4 ? (32'hF << (4 * c)) : 0);
            check("alu_stuck", stuck, c < 3);
            check("alu_wb", wb_en, c < 4);
            check("alu_done", op_done, c == 4);
            check("alu_mem_req", mem_req, 0);
            if (c < 4) check("alu_ctrl", alu_ctrl_q, 3'b010);
            next_cycle();
        end

        // Vector store, ack two cycles after each request
        for (int c = 0; c <= 12; c++) begin
            idle_inputs();
            if (c == 0) begin
                op_valid = 1; alu_sel = 1; mem_write = 1; reg_write = 1; alu_control = 3'b001;
            end
            mem_ack = (c % 3 == 2);
            @(negedge clk);
            check("st_req", mem_req, c < 12);
            check("st_we", mem_we, c < 12);
            check("st_valid", beat_valid, (c % 3 == 2) && c < 12);
            check("st_idx", beat_idx, c < 12 ? c / 3 : 0);
            check("st_stuck", stuck, c < 11);
            check("st_wb", wb_en, 0);
            check("st_done", op_done, c == 12);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Vector load with ack tied high; ack with no request in cycle 4 is ignored
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            mem_ack = 1;
            if (c == 0) begin
                op_valid = 1; alu_sel = 1; mem_to_reg = 1; reg_write = 1;
            end
            @(negedge clk);
            check("ld_req", mem_req, c < 4);
            check("ld_we", mem_we, 0);
            check("ld_valid", beat_valid, c < 4);
            check("ld_idx", beat_idx, c < 4 ? c : 0);
            check("ld_lane", lane_en, c < 4 ? (32'hF << (4 * c)) : 0);
            check("ld_stuck", stuck, c < 3);
            check("ld_wb", wb_en, c < 4);
            check("ld_done", op_done, c == 4);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Scalar op, even with memory flags set, never engages the sequencer
        for (int c = 0; c < 3; c++) begin
            op_valid = 1; alu_sel = 0; mem_write = 1; reg_write = 1; mem_ack = 1;
            @(negedge clk);
            check("sc_stuck", stuck, 0);
            check("sc_valid", beat_valid, 0);
            check("sc_req", mem_req, 0);
            check("sc_done", op_done, 0);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Back-to-back: second op held during the first, accepted in the op_done cycle
        for (int c = 0; c <= 8; c++) begin
            idle_inputs();
            if (c < 8) begin
                op_valid = 1; alu_sel = 1; reg_write = 1;
                alu_control = c == 0 ? 3'b010 : 3'b101;
            end
            @(negedge clk);
            check("b2b_idx", beat_idx, c < 4 ? c : (c < 8 ? c - 4 : 0));
            check("b2b_stuck", stuck, c < 8 && c != 3 && c != 7);
            check("b2b_done", op_done, c == 4 || c == 8);
            check("b2b_ctrl", alu_ctrl_q, c < 4 ? 3'b010 : 3'b101);
            check("b2b_valid", beat_valid, c < 8);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Reset during beat 2 of a load
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            mem_ack = 1;
            if (c == 0) begin
                op_valid = 1; alu_sel = 1; mem_to_reg = 1; reg_write = 1;
            end
            @(negedge clk);
            check("rl_idx", beat_idx, c);
            next_cycle();
        end
        idle_inputs();
        mem_ack = 1;
        #1;
        check("rl_pre_stuck", stuck, 1);
        check("rl_pre_idx", beat_idx, 2);
        rst = 1;
        #1;
        check("rl_stuck", stuck, 0);
        check("rl_req", mem_req, 0);
        check("rl_valid", beat_valid, 0);
        check("rl_idx0", beat_idx, 0);
        next_cycle();
        rst = 0;
        mem_ack = 0;
        @(negedge clk);
        check("rl_done", op_done, 0);
        check("rl_stall", stall_cycles, 0);
        next_cycle();
        @(negedge clk);
        check("rl_done2", op_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_vec_sequencer.md
Name: simd_vec_sequencer

Overview:
- Generates the `stuck` stall signal that the decode-stage control unit consumes. Today that signal is tied low.
- Sits in EX. Takes each decoded op and, for vector ops (`alu_sel`=1), steps the datapath through NBEATS lane-group beats.
- Freezes fetch/decode while the op is in flight, and handshakes with data memory for vector loads/stores.
- Scalar ops pass through with zero stall.

Parameters:
- VEC_LANES, 16, byte lanes per vector (128-bit AES state).
- LANES_PER_BEAT, 4, lanes processed per beat. Must divide VEC_LANES. NBEATS = VEC_LANES/LANES_PER_BEAT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  decoded op present in EX this cycle.
- alu_sel  in  1  1 = vector op, 0 = scalar.
- alu_control  in  3  ALU operation code.
- reg_write  in  1  op writes the register file.
- mem_write  in  1  vector store.
- mem_to_reg  in  1  vector load.
- mem_ack  in  1  memory completed the current beat.
- stuck  out  1  stall to fetch/decode/control unit.
- mem_req  out  1  memory request for the current beat.
- mem_we  out  1  write qualifier accompanying mem_req.
- beat_valid  out  1  datapath commits the current beat.
- beat_idx  out  max(1,$clog2(NBEATS))  current beat number.
- lane_en  out  VEC_LANES  active lane mask.
- alu_ctrl_q  out  3  ALU op held stable for the whole vector op.
- wb_en  out  1  register write-back enable.
- op_done  out  1  one-cycle pulse after the final beat.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset state (async rst high):
  - state=IDLE, beat counter 0.
  - All outputs 0, including stuck, mem_req, op_done, alu_ctrl_q.
  - An op in flight is abandoned; no partial-beat completion.
- FSM states: IDLE, EXEC, MEMWAIT.
- Acceptance: an op is accepted only in IDLE with op_valid=1. op_valid is ignored in EXEC and MEMWAIT.
- Scalar op (alu_sel=0): no state change, stuck=0, no beat or memory outputs, no op_done.
- Vector ALU op (alu_sel=1, mem_write=0, mem_to_reg=0):
  - Beat 0 executes in the acceptance cycle, combinationally: beat_valid=1, beat_idx=0, alu_ctrl_q=alu_control.
  - alu_control and reg_write are latched at acceptance.
  - FSM goes to EXEC. Beats 1..NBEATS-1 execute one per cycle.
  - Return to IDLE after the final beat.
- Vector memory op (alu_sel=1, mem_write=1 or mem_to_reg=1):
  - mem_req=1 from the acceptance cycle; mem_we=mem_write (latched).
  - Each beat holds mem_req and beat_idx stable until mem_ack.
  - beat_valid=1 only in the ack cycle; beat_idx advances the next cycle.
  - mem_ack arriving in the acceptance cycle completes beat 0 immediately.
  - mem_ack while mem_req=0 is ignored.
  - FSM is in MEMWAIT from the cycle after acceptance until the final ack.
  - Simultaneous mem_write=1 and mem_to_reg=1: treated as a store.
- lane_en = beat_valid ? mask of bits [beat_idx*LANES_PER_BEAT +: LANES_PER_BEAT] : 0.
- wb_en = beat_valid & latched reg_write, except on stores, where wb_en=0.
- stuck = 1 whenever a vector op is active (acceptance cycle or non-IDLE) and the current cycle is not its final beat completion.
  - The final beat completion cycle is the last EXEC beat, or the last ack.
  - Consequence: with NBEATS=1, a vector ALU op never stalls.
- op_done: registered, so it is 1 exactly in the cycle after the final beat completion. A new op may be accepted in that same cycle.
- Beat counter wraps to 0 on completion, never by overflow.

Optional Feature:
- Macro: SIMD_SEQ_PERF_CNT_EN.
- Defined: stall_cycles increments each cycle stuck=1, saturates at 32'hFFFF_FFFF, and is cleared by rst.
- Undefined: stall_cycles is tied to 0 and no counter flops are built.

Decomposition:
- Package simd_seq_pkg:
  - seq_state_t enum {IDLE, EXEC, MEMWAIT}.
  - Default constants for VEC_LANES and LANES_PER_BEAT.
  - Function nbeats(vec_lanes, lanes_per_beat).
  - Function beat_mask(idx) returning the lane_en pattern.
- Sub-module simd_beat_counter:
  - Inputs: load, advance.
  - Outputs: idx, last (idx==NBEATS-1).
  - Reset and wrap as specified above.

Test Plan (defaults, NBEATS=4):
- Vector ALU op (alu_control=3'b010, reg_write=1) at cycle 0:
  - beat_idx 0,1,2,3 in cycles 0–3; lane_en 16'h000F, 00F0, 0F00, F000.
  - stuck=1 in cycles 0–2, 0 in cycle 3; op_done=1 in cycle 4; wb_en=1 in cycles 0–3.
- Vector store with mem_ack 2 cycles after each request:
  - mem_req high for 12 cycles, mem_we=1, wb_en=0.
  - beat_valid only on the 4 ack cycles; stuck falls on the 4th ack.
- Vector load with mem_ack tied high:
  - Completes in 4 cycles, identical timing to the ALU case.
- Scalar op, op_valid=1, alu_sel=0:
  - stuck, beat_valid, mem_req and op_done all stay 0.
- Back-to-back vector ops:
  - A second op held on op_valid during the first is ignored.
  - It is accepted in the op_done cycle (cycle 4) and runs cycles 4–7.
- rst asserted during beat 2 of a load:
  - stuck, mem_req and beat_valid drop immediately (asynchronous).
  - No op_done. With SIMD_SEQ_PERF_CNT_EN, stall_cycles reads 0.
